// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // ps2_key field layout
    localparam int KEY_W   = 11;
    localparam int KEY_TGL = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line front end: 2-flop synchronisers, optional clock glitch filter
// (PS2_GLITCH_FILTER_EN), falling-edge strobe on the conditioned clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    if (FILTER_LEN < 1) begin : g_bad_len
        $error("ps2_line_filter: FILTER_LEN must be >= 1");
    end

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_cond;
    logic       clk_cond_d;

    // Lines idle high, so the synchronisers reset high to avoid a false edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] flt_cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_cond <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_sync[1] == clk_cond) begin
            flt_cnt  <= '0;
        end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_cond <= clk_sync[1];
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + 1'b1;
        end
    end
`else
    assign clk_cond = clk_sync[1];
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) clk_cond_d <= 1'b1;
        else          clk_cond_d <= clk_cond;
    end

    assign clk_fall  = clk_cond_d & ~clk_cond;
    assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard frame receiver and E0/F0/E1 prefix resolver producing ps2_key.
// Optional clock glitch filter in the front end: PS2_GLITCH_FILTER_EN.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 9600
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [KEY_W-1:0]  ps2_key,
    output logic              frame_err,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e  state, state_nx;
    logic        clk_fall, data_sync;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        par;
    logic        ext, brk;
    logic [2:0]  skip;
    logic [TW-1:0] tcnt;
    logic        timeout, frame_ok, frame_bad;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (clk_fall),
        .data_sync (data_sync)
    );

    // An edge in the same cycle as the limit wins over the timeout.
    assign timeout = (state != IDLE) && !clk_fall && (tcnt == TW'(TIMEOUT_CYC));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            state_nx  = IDLE;
            frame_bad = 1'b1;
        end else if (clk_fall) begin
            case (state)
                IDLE: begin
                    if (!data_sync) state_nx  = DATA;
                    else            frame_bad = 1'b1;
                end
                DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (data_sync && (^{shift, par})) frame_ok  = 1'b1;
                    else                              frame_bad = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            shift     <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (clk_fall) begin
                tcnt <= '0;
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par <= data_sync;
                    default: ;
                endcase
            end else if (timeout) begin
                tcnt <= '0;
            end else if (state != IDLE) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Prefix/skip handling and the event word.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key   <= '0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
        end else begin
            frame_err <= frame_bad;
            if (frame_bad) begin
                ext  <= 1'b0;
                brk  <= 1'b0;
                skip <= '0;
            end else if (frame_ok) begin
                if (skip != '0) begin
                    skip <= skip - 1'b1;
                    ext  <= 1'b0;
                    brk  <= 1'b0;
                end else begin
                    case (shift)
                        PS2_EXT:   ext  <= 1'b1;
                        PS2_BRK:   brk  <= 1'b1;
                        PS2_PAUSE: skip <= PAUSE_SKIP;
                        default: begin
                            ps2_key <= {~ps2_key[KEY_TGL], ~brk, ext, shift};
                            ext     <= 1'b0;
                            brk     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder; define PS2_GLITCH_FILTER_EN to add the glitch case.
module tb_ps2_scancode_decoder;

    localparam int TO_CYC = 9600;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int upd   = 0;
    int errc  = 0;
    logic [10:0] key_q = '0;

    ps2_scancode_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Count key updates and frame_err high cycles.
    always @(negedge clk_sys) begin
        if (ps2_key !== key_q) upd = upd + 1;
        key_q = ps2_key;
        if (frame_err === 1'b1) errc = errc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (10) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk_sys);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    int u0, e0;
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        repeat (4) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_key",  {21'd0, ps2_key}, 32'h0);
        chk("rst_err",  {31'd0, frame_err}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk_sys);

        // Make
        good(8'h1C);
        @(negedge clk_sys);
        chk("make_1c", {21'd0, ps2_key}, 32'h61C);
        chk("make_err", errc, 0);

        // Break: no update after F0 alone
        u0 = upd;
        good(8'hF0);
        @(negedge clk_sys);
        chk("f0_noupd", upd - u0, 0);
        chk("f0_key", {21'd0, ps2_key}, 32'h61C);
        good(8'h1C);
        @(negedge clk_sys);
        chk("brk_1c", {21'd0, ps2_key}, 32'h01C);

        // Extended
        good(8'hE0);
        good(8'h75);
        @(negedge clk_sys);
        chk("ext_75", {21'd0, ps2_key}, 32'h775);

        // Bad parity
        e0 = errc;
        send_frame(8'h29, 1'b1, 1'b0);
        @(negedge clk_sys);
        chk("par_err", errc - e0, 1);
        chk("par_key", {21'd0, ps2_key}, 32'h775);
        good(8'h29);
        @(negedge clk_sys);
        chk("par_29", {21'd0, ps2_key}, 32'h229);

        // Pause sequence swallowed
        u0 = upd;
        for (int i = 0; i < 8; i++) good(pause_seq[i]);
        @(negedge clk_sys);
        chk("pause_noupd", upd - u0, 0);
        good(8'h1C);
        @(negedge clk_sys);
        chk("pause_1c", {21'd0, ps2_key}, 32'h61C);
        chk("pause_upd1", upd - u0, 1);

        // Timeout after E0 prefix; ext must be cleared
        good(8'hE0);
        e0 = errc;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk_sys);
        chk("to_busy", {31'd0, busy}, 32'h1);
        repeat (TO_CYC + 10) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("to_err", errc - e0, 1);
        chk("to_idle", {31'd0, busy}, 32'h0);
        chk("to_key", {21'd0, ps2_key}, 32'h61C);
        good(8'h5A);
        @(negedge clk_sys);
        chk("to_5a", {21'd0, ps2_key}, 32'h25A);

        // Bad stop bit
        e0 = errc;
        send_frame(8'h33, 1'b0, 1'b1);
        @(negedge clk_sys);
        chk("stop_err", errc - e0, 1);
        chk("stop_key", {21'd0, ps2_key}, 32'h25A);

        // Bad start bit in IDLE
        e0 = errc;
        ps2_bit(1'b1);
        @(negedge clk_sys);
        chk("start_err", errc - e0, 1);
        chk("start_busy", {31'd0, busy}, 32'h0);

        // Reset mid-frame: silent abort
        e0 = errc;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk_sys);
        chk("mid_busy", {31'd0, busy}, 32'h1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("mid_rst_err", errc - e0, 0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_key", {21'd0, ps2_key}, 32'h0);
        good(8'h1C);
        @(negedge clk_sys);
        chk("post_rst_1c", {21'd0, ps2_key}, 32'h61C);

`ifdef PS2_GLITCH_FILTER_EN
        e0 = errc;
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("glitch_err", errc - e0, 0);
        chk("glitch_busy", {31'd0, busy}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Receives the raw PS/2 keyboard clock/data lines and turns the serial byte stream into the 11-bit `ps2_key` event word consumed by the core key-mapping logic: `[10]` toggle, `[9]` pressed, `[8]` extended, `[7:0]` scancode. It resolves `E0` (extended) and `F0` (break) prefixes and swallows the `E1` Pause sequence. It also reports framing, parity and timeout errors. It sits between the board PS/2 pins and the button-decode block, in the `clk_sys` domain.

## Interface
- `FILTER_LEN`, 8: `clk_sys` cycles `ps2_clk` must be stable before a level change is accepted (filter build only).
- `TIMEOUT_CYC`, 9600: idle `clk_sys` cycles between falling edges that abort a partial frame (200 µs at 48 MHz).
- `clk_sys` in 1: system clock, sole clock.
- `reset_n` in 1: **one clock; reset is synchronous and active-low.**
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `ps2_key` out 11: event word; `[10]` toggles once per completed key event.
- `frame_err` out 1: one-cycle pulse on a bad start, parity or stop bit, or on timeout.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Line front end:
  - 2-flop synchroniser on both lines.
  - Falling edge of the conditioned clock = sample `ps2_data`.
- Frame FSM:
  - IDLE: on an edge with data=0, go to DATA with bit count 0. An edge with data=1 raises `frame_err` and stays in IDLE.
  - DATA: shift LSB-first. Go to PARITY after the 8th bit.
  - PARITY: store the bit. Go to STOP.
  - STOP: the frame is good when stop=1 and data bits plus parity have odd weight. Any other case raises `frame_err`. Return to IDLE either way.
- Byte handling on a good frame:
  - `E0`: set ext flag.
  - `F0`: set brk flag.
  - `E1`: load skip counter with 7. The next 7 good bytes are discarded without emitting, and the flags are cleared afterwards.
  - Any other byte: `ps2_key <= {~ps2_key[10], ~brk, ext, byte}`, then clear ext and brk.
- Error or timeout: clear ext, brk and skip counter. `ps2_key` is unchanged.
- Timeout:
  - The counter clears on every accepted edge and counts only outside IDLE.
  - Reaching `TIMEOUT_CYC` forces IDLE and pulses `frame_err`.
  - If an edge arrives in the same cycle the counter hits the limit, the edge wins: it is processed and no timeout occurs.
- Reset:
  - State values: IDLE, `ps2_key`=0, `frame_err`=0, `busy`=0.
  - Flags, shifter, skip and timeout counters all clear.
  - Reset during a frame aborts it silently, with no `frame_err`.

## Timing
- Edge detect latency:
  - Filter build: 2 sync cycles + `FILTER_LEN` + 1 cycles after the pin falls.
  - Non-filter build: 3 cycles.
- `ps2_key` and `frame_err` are registered. They update in the cycle after the STOP-bit edge is detected.
- `frame_err` is high for exactly one cycle per error. It never coincides with a `ps2_key` update.
- Back-to-back frames need no idle gap beyond the PS/2 line protocol.
- `ps2_data` is not filtered. It is sampled from the synchronised value in the edge-detect cycle.

## Configuration
- `PS2_GLITCH_FILTER_EN` defined:
  - Conditioned clock changes only after the synchronised `ps2_clk` has held a new level for `FILTER_LEN` consecutive cycles.
  - Shorter pulses are ignored.
- Not defined:
  - Conditioned clock = synchronised `ps2_clk`.
  - `FILTER_LEN` is unused. Any glitch counts as an edge.

## Structure
- Package `ps2_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP)
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1, `PAUSE_SKIP`=7
  - `ps2_key` field index constants
- Sub-module `ps2_line_filter`: synchroniser, optional glitch filter, falling-edge strobe. It also passes the synchronised data through.
- The top holds the FSM, prefix and skip logic, and the timeout.

## Test plan
- Reset, then frame `1C` with correct parity → `ps2_key`=11'h61C within 1 cycle of the STOP edge; `frame_err` stays 0.
- After that, frames `F0`,`1C` → `ps2_key`=11'h01C (toggle back to 0, released); no update after the `F0` frame alone.
- Frames `E0`,`75` → `ps2_key`=11'h775 from toggle 0.
- Frame `29` with even total weight (bad parity) → one-cycle `frame_err`, `ps2_key` unchanged. A following good `29` → `ps2_key[7:0]`=8'h29 with toggle flipped.
- Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `1C` → no update during the 8 bytes. Exactly one update for `1C`, with ext=0 and pressed=1.
- Timeout and filter:
  - Start bit + 4 data bits, then stall for `TIMEOUT_CYC`+10 → `frame_err` pulse, `busy`=0; the next full frame decodes correctly.
  - With `PS2_GLITCH_FILTER_EN`, a 3-cycle low pulse on `ps2_clk` in IDLE produces no edge and no `frame_err`.
